// File: rtl/upower_rf_pkg.sv
// -----------------------------------------------------------------------------
// upower_rf_pkg
// Shared definitions for the uPower register-file write scheduler.
//   XLEN    : register data width
//   NREGS   : number of architectural registers
//   REG_AW  : register address width
//   wb_src_t: writeback source, used for the arbiter pointer and grant encoding
// -----------------------------------------------------------------------------
package upower_rf_pkg;

    localparam int XLEN   = 64;
    localparam int NREGS  = 32;
    localparam int REG_AW = 5;

    typedef enum logic {
        WB_ALU = 1'b0,
        WB_LD  = 1'b1
    } wb_src_t;

    // The requester that is not 's'; the pointer moves here after a grant.
    function automatic wb_src_t other_src(input wb_src_t s);
        return (s == WB_ALU) ? WB_LD : WB_ALU;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// -----------------------------------------------------------------------------
// rr_arbiter2
// Two-requester round-robin arbiter (ALU vs load writeback).
// A single requester is always granted; on contention the requester named by
// the pointer wins. After any grant the pointer moves to the other requester.
// Grants are forced low while rst is asserted.
//
// Ports
//   clk, rst   : clock, asynchronous active-high reset
//   req_alu    : ALU writeback request
//   req_ld     : load writeback request
//   gnt_alu    : one-hot grant, ALU
//   gnt_ld     : one-hot grant, load
//   gnt_valid  : some requester is granted this cycle
//   gnt_src    : which requester is granted (meaningful when gnt_valid)
// -----------------------------------------------------------------------------
module rr_arbiter2
    import upower_rf_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    req_alu,
    input  logic    req_ld,
    output logic    gnt_alu,
    output logic    gnt_ld,
    output logic    gnt_valid,
    output wb_src_t gnt_src
);

    wb_src_t pref;
    wb_src_t pref_next;

    // State register
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the values present before the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pref <= WB_ALU;
        end else begin
            pref <= pref_next;
        end
    end

    // Next-state logic
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        pref_next = pref;
        if (gnt_valid) begin
            pref_next = other_src(gnt_src);
        end
    end

    // Output logic
    always_comb begin
        gnt_valid = 1'b0;
        gnt_src   = WB_ALU;
        if (!rst) begin
            if (req_alu && req_ld) begin
                gnt_valid = 1'b1;
                gnt_src   = pref;
            end else if (req_alu) begin
                gnt_valid = 1'b1;
                gnt_src   = WB_ALU;
            end else if (req_ld) begin
                gnt_valid = 1'b1;
                gnt_src   = WB_LD;
            end
        end
        gnt_alu = gnt_valid && (gnt_src == WB_ALU);
        gnt_ld  = gnt_valid && (gnt_src == WB_LD);
    end

endmodule

// File: rtl/regfile_write_scheduler.sv
// -----------------------------------------------------------------------------
// regfile_write_scheduler
// Shares the register file's single write port between the ALU and load
// writeback paths (round-robin), registers the winning write onto the port,
// and keeps a pending-write scoreboard so decode can detect RAW/WAW hazards.
//
// Optional feature macro: RF_BYPASS_EN
//   defined   : hazards clear during the commit cycle itself and the
//               byp_hit_x / byp_data_x ports forward the committing data.
//   undefined : hazards clear the cycle after the commit; no bypass ports.
//
// Ports
//   clk, rst                  : clock, asynchronous active-high reset
//   alu_valid/rd/data, alu_ready : ALU writeback request / accept
//   ld_valid/rd/data,  ld_ready  : load writeback request / accept
//   iss_valid, iss_rd, iss_ready : destination reservation from decode
//   chk_a, chk_b              : source registers to check
//   hazard_a, hazard_b        : source has an uncommitted pending write
//   flush                     : squash all reservations
//   rf_we, rf_waddr, rf_wdata : register-file write port
//   byp_hit_a/b, byp_data_a/b : forwarding of the committing write (bypass build)
// -----------------------------------------------------------------------------
module regfile_write_scheduler
    import upower_rf_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    input  logic [REG_AW-1:0] alu_rd,
    input  logic [XLEN-1:0]   alu_data,
    output logic              alu_ready,
    input  logic              ld_valid,
    input  logic [REG_AW-1:0] ld_rd,
    input  logic [XLEN-1:0]   ld_data,
    output logic              ld_ready,
    input  logic              iss_valid,
    input  logic [REG_AW-1:0] iss_rd,
    output logic              iss_ready,
    input  logic [REG_AW-1:0] chk_a,
    input  logic [REG_AW-1:0] chk_b,
    output logic              hazard_a,
    output logic              hazard_b,
    input  logic              flush,
`ifdef RF_BYPASS_EN
    output logic              byp_hit_a,
    output logic              byp_hit_b,
    output logic [XLEN-1:0]   byp_data_a,
    output logic [XLEN-1:0]   byp_data_b,
`endif
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [XLEN-1:0]   rf_wdata
);

    logic              gnt_valid;
    wb_src_t           gnt_src;
    logic [REG_AW-1:0] sel_rd;
    logic [XLEN-1:0]   sel_data;
    logic [NREGS-1:0]  pending;
    logic [NREGS-1:0]  pending_next;

    rr_arbiter2 u_arb (
        .clk       (clk),
        .rst       (rst),
        .req_alu   (alu_valid),
        .req_ld    (ld_valid),
        .gnt_alu   (alu_ready),
        .gnt_ld    (ld_ready),
        .gnt_valid (gnt_valid),
        .gnt_src   (gnt_src)
    );

    // Winning request steered to the commit register.
    always_comb begin
        sel_rd   = alu_rd;
        sel_data = alu_data;
        if (gnt_src == WB_LD) begin
            sel_rd   = ld_rd;
            sel_data = ld_data;
        end
    end

    // Commit register: address/data hold when nothing is granted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            rf_we <= gnt_valid;
            if (gnt_valid) begin
                rf_waddr <= sel_rd;
                rf_wdata <= sel_data;
            end
        end
    end

    // Reservations are only blocked by an existing one (no WAW in flight).
    assign iss_ready = !pending[iss_rd];

    // Scoreboard update order: clear on commit, then set on issue (set wins),
    // then flush overrides everything.
    always_comb begin
        pending_next = pending;
        if (rf_we) begin
            pending_next[rf_waddr] = 1'b0;
        end
        if (iss_valid && iss_ready) begin
            pending_next[iss_rd] = 1'b1;
        end
        if (flush) begin
            pending_next = '0;
        end
    end

    // NOTE: the scoreboard is a flop vector, not a RAM, so it is reset with
    // the rest of the state; decode must never see stale reservations.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
        end else begin
            pending <= pending_next;
        end
    end

`ifdef RF_BYPASS_EN
    // The consumer reads the register in the commit cycle, so a matching
    // in-flight write both clears the hazard and supplies the data.
    assign byp_hit_a  = rf_we && (rf_waddr == chk_a);
    assign byp_hit_b  = rf_we && (rf_waddr == chk_b);
    assign byp_data_a = byp_hit_a ? rf_wdata : '0;
    assign byp_data_b = byp_hit_b ? rf_wdata : '0;
    assign hazard_a   = pending[chk_a] && !byp_hit_a;
    assign hazard_b   = pending[chk_b] && !byp_hit_b;
`else
    assign hazard_a = pending[chk_a];
    assign hazard_b = pending[chk_b];
`endif

endmodule
